fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and FSM states.
package fetch_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_ISSUE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: reads program memory at the external PC, holds the result in ir
// until downstream takes it, and handles redirects including one in flight to memory.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] pc_q,
  output logic [AW-1:0] pc_d,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          br_take,
  input  logic [AW-1:0] br_target
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          load_addr;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    load_addr = 1'b0;
    case (state_q)
      S_START: begin
        pc_d      = br_take ? br_target : '0;
        state_d   = S_FETCH;
        load_addr = 1'b1;
      end
      S_FETCH: begin
        if (br_take) begin
          pc_d = br_target;
          if (mem_ack) begin
            state_d   = S_FETCH;
            load_addr = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      // The outstanding read still belongs to the old address; wait it out with addr held.
      S_DRAIN: begin
        if (br_take) pc_d = br_target;
        if (mem_ack) begin
          state_d   = S_FETCH;
          load_addr = 1'b1;
        end
      end
      S_ISSUE: begin
        if (br_take) begin
          pc_d      = br_target;
          state_d   = S_FETCH;
          load_addr = 1'b1;
        end else if (ir_ready) begin
          state_d   = S_FETCH;
          load_addr = 1'b1;
        end
      end
      default: state_d = S_START;
    endcase
    if (load_addr) addr_d = pc_d;
    // Drives the external PC to zero on the reset edge as well.
    if (!clr) pc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_START;
      addr_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign mem_addr = addr_q;
  assign ir       = ir_q;
  assign ir_valid = (state_q == S_ISSUE);

endmodule
